// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 program loader: FSM state encoding and default geometry.
package sap1_pkg;

    localparam int SAP1_MEM_DEPTH = 16;
    localparam int SAP1_ADDR_W    = 4;
    localparam int SAP1_DATA_W    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } sap1_state_e;

endpackage

// File: rtl/sap1_checksum_acc.sv
// 8-bit clear/accumulate register that forms the mod-256 sum of program bytes.
module sap1_checksum_acc
    import sap1_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   acc_en,
    input  logic [SAP1_DATA_W-1:0] data,
    output logic [SAP1_DATA_W-1:0] sum
);

    logic [SAP1_DATA_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (acc_en) begin
            sum_d = sum_q + data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/sap1_prog_loader.sv
// Streams MEM_DEPTH program bytes into the SAP-1 RAM and holds the CPU until the load completes.
// Define SAP1_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte before release.
module sap1_prog_loader
    import sap1_pkg::*;
#(
    parameter int MEM_DEPTH = SAP1_MEM_DEPTH,
    parameter int ADDR_W    = SAP1_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   in_valid,
    input  logic [SAP1_DATA_W-1:0] in_data,
    output logic                   in_ready,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [SAP1_DATA_W-1:0] mem_wdata,
    output logic                   cpu_hold,
    output logic                   load_done,
    output logic                   load_err
);

    sap1_state_e            state_q, state_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [SAP1_DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic                   last_beat;
    logic                   released;

    assign last_beat = (cnt_q == ADDR_W'(MEM_DEPTH - 1));

`ifdef SAP1_LOADER_CHECKSUM_EN
    logic [SAP1_DATA_W-1:0] sum;
    logic                   acc_en;

    assign acc_en = (state_q == LOAD) && in_valid && !load_start;

    sap1_checksum_acc u_checksum_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (load_start),
        .acc_en (acc_en),
        .data   (in_data),
        .sum    (sum)
    );
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE, RUN, ERR: begin
                if (load_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                // A restart request wins over a beat presented in the same cycle.
                if (load_start) begin
                    cnt_d = '0;
                end else if (in_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q;
                    mem_wdata_d = in_data;
                    if (last_beat) begin
`ifdef SAP1_LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = RUN;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef SAP1_LOADER_CHECKSUM_EN
            CHECK: begin
                if (load_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else if (in_valid) begin
                    state_d = (in_data == sum) ? RUN : ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // The CPU stays held while the final write strobe is still on the RAM port.
    assign released  = (state_q == RUN) && !mem_we_q;

    assign in_ready  = (state_q == LOAD) || (state_q == CHECK);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = !released;
    assign load_done = released;
`ifdef SAP1_LOADER_CHECKSUM_EN
    assign load_err  = (state_q == ERR);
`else
    assign load_err  = 1'b0;
`endif

endmodule

// File: tb/tb_sap1_prog_loader.sv
// Directed testbench for sap1_prog_loader; checksum scenarios run when SAP1_LOADER_CHECKSUM_EN is defined.
module tb_sap1_prog_loader;
    import sap1_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, mem_we, cpu_hold, load_done, load_err;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;

    int checks = 0;
    int errors = 0;
    int n_wr = 0;
    int base;
    logic [3:0] cap_addr [0:255];
    logic [7:0] cap_data [0:255];
    logic [7:0] ram_model [0:15];
    logic [7:0] exp_sum = 8'h00;

    sap1_prog_loader #(.MEM_DEPTH(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    // RAM-side capture of every write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            if (n_wr < 256) begin
                cap_addr[n_wr] <= mem_addr;
                cap_data[n_wr] <= mem_wdata;
            end
            ram_model[mem_addr] <= mem_wdata;
            n_wr <= n_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end else begin
            $display("ok   %s = %0h", tag, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick(1);
        in_valid = 1'b0;
        $display("beat %02h", d);
    endtask

    task automatic do_load_start();
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
        exp_sum = 8'h00;
        $display("load_start");
    endtask

    task automatic send_beats(input logic [7:0] b, input logic [7:0] step, input int n);
        for (int i = 0; i < n; i++) begin
            exp_sum = exp_sum + (b + 8'(i) * step);
            beat(b + 8'(i) * step);
        end
    endtask

    task automatic finish_prog();
        $display("end of program, checksum %02h", exp_sum);
`ifdef SAP1_LOADER_CHECKSUM_EN
        beat(exp_sum);
`else
        tick(1);
`endif
    endtask

    initial begin
        // Reset with load_start and in_valid asserted: reset must win.
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h55;
        tick(3);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_load_done", load_done, 0);
        chk("rst_load_err", load_err, 0);
        load_start = 1'b0;
        rst = 1'b1;
        tick(3);
        in_valid = 1'b0;
        chk("idle_in_ready", in_ready, 0);
        chk("idle_no_write", n_wr, 0);
        chk("idle_cpu_hold", cpu_hold, 1);

        // Back-to-back program 0x10..0x1F.
        base = n_wr;
        do_load_start();
        chk("load_in_ready", in_ready, 1);
        chk("load_cpu_hold", cpu_hold, 1);
        send_beats(8'h10, 8'h01, 16);
        chk("last_we", mem_we, 1);
        chk("last_addr", mem_addr, 15);
        chk("last_wdata", mem_wdata, 8'h1F);
        chk("last_done_low", load_done, 0);
        chk("last_hold_high", cpu_hold, 1);
        finish_prog();
        chk("run_done", load_done, 1);
        chk("run_hold", cpu_hold, 0);
        chk("run_we", mem_we, 0);
        chk("run_in_ready", in_ready, 0);
        chk("run_err", load_err, 0);
        chk("run_addr_hold", mem_addr, 15);
        chk("b2b_count", n_wr - base, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("b2b_addr%0d", i), cap_addr[base + i], i);
            chk($sformatf("b2b_data%0d", i), cap_data[base + i], 8'h10 + i);
        end
        base = n_wr;
        in_valid = 1'b1;
        tick(3);
        in_valid = 1'b0;
        chk("run_ignores_valid", n_wr - base, 0);

        // in_valid toggled every other cycle.
        base = n_wr;
        do_load_start();
        for (int i = 0; i < 32; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 8'h40 + 8'(i / 2);
            if (i % 2 == 0) exp_sum = exp_sum + in_data;
            tick(1);
        end
        in_valid = 1'b0;
        finish_prog();
        chk("tog_done", load_done, 1);
        chk("tog_count", n_wr - base, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tog_addr%0d", i), cap_addr[base + i], i);
            chk($sformatf("tog_data%0d", i), cap_data[base + i], 8'h40 + i);
        end

        // Restart after beat 7, with a discarded beat in the restart cycle.
        base = n_wr;
        do_load_start();
        send_beats(8'h50, 8'h01, 7);
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'hEE;
        tick(1);
        load_start = 1'b0;
        in_valid   = 1'b0;
        exp_sum    = 8'h00;
        chk("rs_in_ready", in_ready, 1);
        send_beats(8'hA0, 8'h01, 16);
        finish_prog();
        chk("rs_done", load_done, 1);
        chk("rs_count", n_wr - base, 23);
        chk("rs_restart_addr", cap_addr[base + 7], 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("rs_ram%0d", i), ram_model[i], 8'hA0 + i);
        end

        // Reset after beat 5 while beats keep coming.
        base = n_wr;
        do_load_start();
        send_beats(8'h60, 8'h01, 6);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick(3);
        chk("mr_count", n_wr - base, 6);
        chk("mr_cpu_hold", cpu_hold, 1);
        chk("mr_in_ready", in_ready, 0);
        chk("mr_done", load_done, 0);
        chk("mr_we", mem_we, 0);
        chk("mr_addr", mem_addr, 0);
        rst = 1'b1;
        tick(3);
        chk("mr_idle_ready", in_ready, 0);
        chk("mr_idle_nowrite", n_wr - base, 6);
        chk("mr_idle_hold", cpu_hold, 1);
        in_valid = 1'b0;

        // load_start from RUN.
        do_load_start();
        send_beats(8'h30, 8'h01, 16);
        finish_prog();
        chk("r2l_done", load_done, 1);
        do_load_start();
        chk("r2l_hold", cpu_hold, 1);
        chk("r2l_done_low", load_done, 0);
        chk("r2l_in_ready", in_ready, 1);
        send_beats(8'h80, 8'h02, 16);
        finish_prog();
        chk("r2l_done2", load_done, 1);
        chk("r2l_ram0", ram_model[0], 8'h80);
        chk("r2l_ram15", ram_model[15], 8'h9E);

`ifdef SAP1_LOADER_CHECKSUM_EN
        // Good and bad checksum on a program of sixteen 0x01 bytes.
        do_load_start();
        send_beats(8'h01, 8'h00, 16);
        chk("cs_check_hold", cpu_hold, 1);
        chk("cs_check_ready", in_ready, 1);
        beat(8'h10);
        chk("cs_ok_done", load_done, 1);
        chk("cs_ok_err", load_err, 0);
        do_load_start();
        chk("cs_restart_err", load_err, 0);
        base = n_wr;
        send_beats(8'h01, 8'h00, 16);
        beat(8'h11);
        chk("cs_bad_err", load_err, 1);
        chk("cs_bad_hold", cpu_hold, 1);
        chk("cs_bad_done", load_done, 0);
        chk("cs_bad_ready", in_ready, 0);
        chk("cs_no_csum_write", n_wr - base, 16);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sap1_prog_loader.md
SAP1_PROG_LOADER -- requirements
Module: sap1_prog_loader

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 16, meaning the number of SAP-1 RAM words loaded per program.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning the RAM address width, with MEM_DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port load_start, input, 1 bit: single-cycle request to begin or restart a program load.
REQ-006 The block SHALL have port in_valid, input, 1 bit: a program byte is present on in_data.
REQ-007 The block SHALL have port in_data, input, 8 bits: the program byte.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 The block SHALL have port mem_we, output, 1 bit: write strobe to the SAP-1 RAM.
REQ-010 The block SHALL have port mem_addr, output, ADDR_W bits: RAM write address.
REQ-011 The block SHALL have port mem_wdata, output, 8 bits: RAM write data.
REQ-012 The block SHALL have port cpu_hold, output, 1 bit: holds the SAP-1 CPU in reset while high.
REQ-013 The block SHALL have port load_done, output, 1 bit: the program is loaded and the CPU is released.
REQ-014 The block SHALL have port load_err, output, 1 bit: the load failed the checksum (with the checksum feature only).

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, CHECK, RUN and ERR.
REQ-016 A beat SHALL transfer on a rising clk edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in LOAD and CHECK.
REQ-017 From IDLE, RUN or ERR, load_start=1 SHALL enter LOAD with the address counter at 0, cpu_hold=1, load_done=0 and load_err=0.
REQ-018 load_start=1 while in LOAD or CHECK SHALL restart the load: counter to 0, sum cleared, and any beat in that cycle discarded.
REQ-019 Each accepted LOAD beat SHALL produce mem_we=1 for exactly one cycle on the next cycle, with mem_addr = beat index and mem_wdata = beat byte (registered, latency 1).
REQ-020 mem_we SHALL be 0 in every other cycle, and mem_addr/mem_wdata SHALL hold their last values.
REQ-021 The address counter SHALL increment per accepted LOAD beat; the beat at index MEM_DEPTH-1 SHALL leave LOAD without wrapping to 0.
REQ-022 In IDLE, RUN and ERR, in_valid SHALL be ignored and the RAM SHALL not be written.
REQ-023 In RUN, cpu_hold SHALL be 0 and load_done SHALL be 1, asserted in the cycle after the final write strobe.
REQ-024 In IDLE, cpu_hold SHALL be 1.

Reset
REQ-025 While rst=0 at a rising edge, the FSM SHALL enter IDLE, and the counter and sum SHALL clear to 0.
REQ-026 Reset values SHALL be: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0.
REQ-027 Reset SHALL override load_start and in_valid in the same cycle.
REQ-028 Reset in mid-load SHALL abandon the load with no further write strobe.

Configuration
REQ-029 The checksum feature SHALL be controlled by macro SAP1_LOADER_CHECKSUM_EN.
REQ-030 With SAP1_LOADER_CHECKSUM_EN defined, the last LOAD beat SHALL move the FSM to CHECK.
REQ-031 In CHECK, one further byte SHALL be accepted and SHALL not be written to RAM.
REQ-032 If that byte equals the mod-256 sum of the MEM_DEPTH program bytes, the FSM SHALL go to RUN; otherwise it SHALL go to ERR (cpu_hold=1, load_err=1, load_done=0).
REQ-033 Without SAP1_LOADER_CHECKSUM_EN, the last LOAD beat SHALL go directly to RUN, CHECK and ERR SHALL be unreachable, and load_err SHALL be tied to 0.

Structure
REQ-034 Shared package sap1_pkg SHALL hold the FSM state typedef, SAP1_MEM_DEPTH=16, SAP1_ADDR_W=4 and SAP1_DATA_W=8.
REQ-035 The single sub-module sap1_checksum_acc SHALL be an 8-bit clear/accumulate register, instantiated only under SAP1_LOADER_CHECKSUM_EN.

Verification
REQ-036 Scenario: reset, then 16 beats 0x10..0x1F back-to-back, checksum disabled -> 16 strobes at addr 0..15 with data 0x10..0x1F, then load_done=1 and cpu_hold=0.
REQ-037 Scenario: checksum enabled, 16 bytes 0x01, then checksum 0x10 -> RUN, load_err=0; with checksum 0x11 instead -> ERR, load_err=1, cpu_hold=1.
REQ-038 Scenario: in_valid toggled every other cycle during load -> strobes only for transferred beats, addresses contiguous 0..15.
REQ-039 Scenario: load_start at beat 7, then 16 beats 0xA0..0xAF -> addresses restart at 0, final RAM contents 0xA0..0xAF.
REQ-040 Scenario: rst=0 after beat 5 -> no strobe after the reset edge, IDLE, cpu_hold=1; in_valid=1 in IDLE -> in_ready=0 and no writes.
REQ-041 Scenario: load_start while in RUN -> cpu_hold=1 and load_done=0 in the next cycle, and a fresh load is accepted.
